// File: rtl/i2c_master_seq.sv
// Single-master I2C sequencer: one single-byte read or write per request.
// START, address+R/W, ACK, data byte, ACK/NACK, STOP on open-drain SCL/SDA.
module i2c_master_seq #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] wdata,
  output logic       ready,
  output logic       done,
  output logic       nack,
  output logic [7:0] rdata,
  output logic       busy,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe
);

  localparam logic [15:0] CNT_MAX = 16'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_AACK, S_WDATA,
    S_DACK, S_RDATA, S_MACK, S_STOP, S_DONE
  } state_t;

  state_t      state, nstate;
  logic [1:0]  q, nq;
  logic [2:0]  bitc, nbitc;
  logic [15:0] cnt;
  logic [7:0]  a_byte, w_byte, rx;
  logic        rw_l, ack_smp;
  logic        hold, tick, accept, bitval, n_scl, n_sda;

  // Next bus position; outputs are registered from it so lines change
  // on the same edge that enters a quarter.
  always_comb begin
    hold   = !scl_oe && !scl_in;
    tick   = (cnt == CNT_MAX) && !hold;
    accept = ready && req && scl_in && sda_in;
    nstate = state;
    nq     = q;
    nbitc  = bitc;
    case (state)
      S_IDLE: begin
        if (accept) begin
          nstate = S_START;
          nq     = '0;
          nbitc  = '0;
        end
      end
      S_DONE: nstate = S_IDLE;
      default: begin
        if (tick) begin
          nq = q + 2'd1;
          if (q == 2'd3) begin
            case (state)
              S_START: nstate = S_ADDR;
              S_ADDR: begin
                nbitc = bitc + 3'd1;
                if (bitc == 3'd7) nstate = S_AACK;
              end
              S_AACK:  nstate = ack_smp ? S_STOP : (rw_l ? S_RDATA : S_WDATA);
              S_WDATA: begin
                nbitc = bitc + 3'd1;
                if (bitc == 3'd7) nstate = S_DACK;
              end
              S_RDATA: begin
                nbitc = bitc + 3'd1;
                if (bitc == 3'd7) nstate = S_MACK;
              end
              S_DACK, S_MACK: nstate = S_STOP;
              S_STOP:  nstate = S_DONE;
              default: nstate = S_IDLE;
            endcase
          end
        end
      end
    endcase
  end

  always_comb begin
    case (nstate)
      S_ADDR:  bitval = a_byte[3'd7 - nbitc];
      S_WDATA: bitval = w_byte[3'd7 - nbitc];
      default: bitval = 1'b1;
    endcase
    n_scl = 1'b0;
    n_sda = 1'b0;
    case (nstate)
      S_START: begin
        n_scl = (nq == 2'd3);
        n_sda = nq[1];
      end
      S_STOP: begin
        n_scl = (nq == 2'd0);
        n_sda = !nq[1];
      end
      S_ADDR, S_AACK, S_WDATA, S_DACK, S_RDATA, S_MACK: begin
        n_scl = !nq[1];
        n_sda = !bitval;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      q       <= '0;
      bitc    <= '0;
      cnt     <= '0;
      a_byte  <= '0;
      w_byte  <= '0;
      rx      <= '0;
      rw_l    <= 1'b0;
      ack_smp <= 1'b0;
      ready   <= 1'b1;
      done    <= 1'b0;
      nack    <= 1'b0;
      rdata   <= '0;
      busy    <= 1'b0;
      scl_oe  <= 1'b0;
      sda_oe  <= 1'b0;
    end else begin
      state <= nstate;
      q     <= nq;
      bitc  <= nbitc;
      if (state == S_IDLE || state == S_DONE || tick)
        cnt <= '0;
      else if (!hold)
        cnt <= cnt + 16'd1;
      if (accept) begin
        a_byte  <= {addr, rw};
        w_byte  <= wdata;
        rw_l    <= rw;
        nack    <= 1'b0;
        ack_smp <= 1'b0;
      end
      // SDA is sampled on the edge that ends q2 (SCL high)
      if (tick && q == 2'd2) begin
        case (state)
          S_AACK, S_DACK: begin
            ack_smp <= sda_in;
            if (sda_in) nack <= 1'b1;
          end
          S_RDATA: rx <= {rx[6:0], sda_in};
          default: ;
        endcase
      end
      if (state == S_STOP && nstate == S_DONE && rw_l && !nack)
        rdata <= rx;
      ready  <= (nstate == S_IDLE);
      busy   <= (nstate != S_IDLE);
      done   <= (nstate == S_DONE);
      scl_oe <= n_scl;
      sda_oe <= n_sda;
    end
  end

endmodule

// File: doc/i2c_master_seq.md
Name: i2c_master_seq

Overview:
- Single-master I2C transaction sequencer.
- Drives open-drain SCL/SDA to perform one single-byte transaction per request: START, 7-bit address plus R/W, slave ACK, one data byte (write or read), ACK/NACK, STOP.
- Sits beside the team's passive I2C bus-state monitor and generates the bus sequences that monitor tracks; a host-side register block issues its requests.

Parameters:
CLK_DIV, 4, clk cycles per SCL quarter-period (legal range 2..65535).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req  in  1  transaction request; accepted when req && ready at a clk edge
addr  in  7  slave address, latched at acceptance
rw  in  1  0=write, 1=read, latched at acceptance
wdata  in  8  write byte, latched at acceptance
ready  out  1  high in IDLE only
done  out  1  one-cycle pulse at transaction end
nack  out  1  result flag; 1 = slave NACKed address or write data; valid with done, held until next acceptance
rdata  out  8  read byte; valid with done, held until next acceptance
busy  out  1  high from the cycle after acceptance until the done cycle, inclusive
scl_in  in  1  sampled SCL line
sda_in  in  1  sampled SDA line
scl_oe  out  1  1 = pull SCL low, 0 = release
sda_oe  out  1  1 = pull SDA low, 0 = release

Behaviour:
- Reset values: scl_oe=0, sda_oe=0, ready=1, done=0, nack=0, rdata=0, busy=0; state IDLE.
- All outputs are registered.
- Reset mid-transaction:
  - Both lines released at the next edge.
  - Returns to IDLE; no done pulse.
  - Latched request is discarded.
- Acceptance: in IDLE, req=1 and scl_in=sda_in=1 accepts the request. If either line is low, the request waits; req must stay high.
- Quarter timer:
  - Counts CLK_DIV cycles per quarter q0..q3.
  - The first START quarter begins the cycle after acceptance.
- Clock stretching: in any quarter where scl_oe=0 and scl_in=0, the timer holds until scl_in=1.
- States and line values per quarter:
  - START: q0,q1 both released; q2 sda low; q3 sda low and scl low.
  - ADDR: 8 bits, MSB first (addr[6:0], then rw).
  - Every bit cell (ADDR, WDATA, and all ACK cells):
    - q0: scl low, sda set (0 -> oe=1, 1 -> oe=0).
    - q1: scl low, sda held.
    - q2, q3: scl released, sda held.
    - sda_in is sampled on the edge ending q2.
  - AACK: sda released; sampled 1 -> nack=1, go to STOP; 0 -> go to WDATA (rw=0) or RDATA (rw=1).
  - WDATA: 8 bits of wdata, MSB first, then DACK (sample; 1 -> nack=1). Then STOP.
  - RDATA: sda released for 8 cells; shift sda_in into rdata, MSB first. Then MACK: master releases sda (NACK). Then STOP.
  - STOP:
    - q0: scl low, sda low.
    - q1: scl released, sda low.
    - q2: both released.
    - q3: both released.
  - DONE: one cycle; done=1, busy=1, ready=0. Next cycle IDLE (ready=1).
- Quarter counts, without stretching:
  - Full transaction: 80 quarters; done rises 80*CLK_DIV+1 cycles after the accepting edge.
  - Address NACK: 44 quarters (done at 44*CLK_DIV+1).
- Bit counter: 3 bits, wraps 7 -> 0 on the transition to the ACK cell.
- req during busy is ignored and not queued.

Test Plan:
1. CLK_DIV=4, write addr=0x50, wdata=0xA5, bench slave ACKs both -> SDA bits 1010000,0,ack,10100101,ack; START (SDA falls while SCL high) and STOP (SDA rises while SCL high) present; done exactly 321 cycles after acceptance; nack=0.
2. Write addr=0x50, slave leaves SDA high at AACK -> STOP directly after AACK; no data cells; done at cycle 177; nack=1.
3. Read addr=0x50 rw=1, slave drives 0x3C -> rdata=0x3C at done; sda_oe=0 throughout MACK; nack=0; done at cycle 321.
4. Clock stretch: bench holds scl_in low 10 cycles at ADDR bit 3 q2 -> timer holds; SDA unchanged during hold; done at cycle 331.
5. Reset asserted during WDATA bit 5 q1 -> scl_oe=sda_oe=0 at next edge; ready=1; no done pulse; a new request afterwards completes normally.
6. req raised while sda_in=0 for 20 cycles -> ready stays 1, busy 0, no bus activity; acceptance on the first edge with both lines high.
